// File: rtl/rs15_pkg.sv
// Shared constants and types for the RS(15,11) syndrome framing stage.
// Holds codeword geometry, the syndrome-set type, the FIFO entry layout
// and the framing state encoding used by syndrome_frame_ctrl.
package rs15_pkg;

    localparam int N_SYM    = 15;           // symbols per codeword
    localparam int SYM_W    = 4;            // GF(16) symbol width
    localparam int N_SYN    = 4;            // syndromes per codeword (2t)
    localparam int CW_CNT_W = 4;            // width of the symbol counter
    localparam int SET_W    = N_SYN * SYM_W;

    // One syndrome set, lane 0 (S1) in the least significant nibble.
    typedef logic [N_SYN-1:0][SYM_W-1:0] syn_set_t;

    // FIFO entry: the set plus its precomputed all-zero flag.
    typedef struct packed {
        logic     zero;
        syn_set_t set;
    } fifo_word_t;

    // Framing states.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Feedback masks driven to the syndrome cells.
    localparam logic [SYM_W-1:0] CTRL_CLEAR = '0;
    localparam logic [SYM_W-1:0] CTRL_PASS  = '1;

    // True when every syndrome in the set is zero (codeword clean).
    function automatic logic is_zero_set(input syn_set_t s);
        return (s == '0);
    endfunction

endpackage

// File: rtl/syndrome_frame_ctrl_syn_fifo.sv
// syn_fifo: small synchronous FIFO for syndrome sets.
// The head entry is held in an output register so downstream sees a
// registered set and zero flag; pointers carry one extra wrap bit so
// full and empty can be told apart. DEPTH must be a power of two >= 2.
module syn_fifo
    import rs15_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  fifo_word_t wdata,
    output fifo_word_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_word_t    mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   wr_ptr_d, rd_ptr_d;
    logic          do_push, do_pop;
    fifo_word_t    head_q, head_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot first, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointers and the entry that will sit at the head after this edge.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head_d   = '0;
        if (wr_ptr_d != rd_ptr_d) begin
            // The word being written becomes the head when it lands in the
            // slot the read pointer is about to point at.
            if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
                head_d = wdata;
            else
                head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; only pointers and the head register need one.
        if (do_push)
            mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

    // Pointer and head-register update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    assign head = head_q;

endmodule

// File: rtl/syndrome_frame_ctrl.sv
// syndrome_frame_ctrl: framing and capture stage around the four RS(15,11)
// syndrome cells. Counts symbols, drives the shared CONTROL feedback mask,
// captures the cell outputs on the 15th symbol and queues the set for the
// key-equation stage over a valid/ready handshake.
// Optional build macro SYN_ERR_COUNT_EN adds ERR_CW_CNT, a saturating count
// of captured codewords whose syndrome set is nonzero.
module syndrome_frame_ctrl
    import rs15_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               CLK,
    input  logic               RESET_GLOBAL,
    input  logic               IN_VALID,
    input  logic               IN_SOF,
    output logic [SYM_W-1:0]   CONTROL,
    input  logic [SET_W-1:0]   SYN_IN,
    output logic [SET_W-1:0]   SYN_OUT,
    output logic               SYN_ZERO,
    output logic               SYN_VALID,
    input  logic               SYN_READY,
    output logic               FRAME_ERR,
    output logic               OVERFLOW
`ifdef SYN_ERR_COUNT_EN
    ,
    output logic [7:0]         ERR_CW_CNT
`endif
);

    localparam logic [CW_CNT_W-1:0] LAST_IDX = CW_CNT_W'(N_SYM - 1);

    logic [0:0]          state_q, state_d;
    logic [CW_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic                capture, abort;
    logic                frame_err_q, overflow_q;
    logic                restart;
    logic                pop;
    logic                fifo_full, fifo_empty;
    fifo_word_t          push_word, head_word;

    assign restart = IN_VALID && IN_SOF;

    // Framing decisions: start, count, capture on the 15th symbol, abort.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Stray symbols without SOF are ignored here.
                if (restart) begin
                    state_d   = ST_ACCUM;
                    sym_cnt_d = CW_CNT_W'(1);
                end
            end
            ST_ACCUM: begin
                if (!IN_VALID) begin
                    abort     = 1'b1;
                    state_d   = ST_IDLE;
                    sym_cnt_d = '0;
                end else if (IN_SOF) begin
                    // A new SOF mid-codeword drops the partial word and
                    // starts over with this symbol as symbol one.
                    abort     = 1'b1;
                    sym_cnt_d = CW_CNT_W'(1);
                end else if (sym_cnt_q == LAST_IDX) begin
                    capture   = 1'b1;
                    state_d   = ST_IDLE;
                    sym_cnt_d = '0;
                end else begin
                    sym_cnt_d = sym_cnt_q + CW_CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sym_cnt_d = '0;
            end
        endcase
    end

    // Feedback mask: cleared whenever the current symbol opens a codeword.
    always_comb begin
        CONTROL = CTRL_PASS;
        if ((state_q == ST_IDLE) || restart)
            CONTROL = CTRL_CLEAR;
    end

    // Framing state, symbol counter and one-cycle status pulses.
    always_ff @(posedge CLK) begin
        if (RESET_GLOBAL) begin
            state_q     <= ST_IDLE;
            sym_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            frame_err_q <= abort;
            overflow_q  <= capture && fifo_full && !pop;
        end
    end

    // The cell outputs are combinational, so SYN_IN already holds the final
    // set during the 15th symbol, before the cell registers update.
    assign push_word.zero = is_zero_set(syn_set_t'(SYN_IN));
    assign push_word.set  = syn_set_t'(SYN_IN);

    assign pop = SYN_VALID && SYN_READY;

    syn_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_syn_fifo (
        .clk   (CLK),
        .rst   (RESET_GLOBAL),
        .push  (capture),
        .pop   (pop),
        .wdata (push_word),
        .head  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign SYN_VALID = !fifo_empty;
    assign SYN_OUT   = head_word.set;
    assign SYN_ZERO  = head_word.zero;
    assign FRAME_ERR = frame_err_q;
    assign OVERFLOW  = overflow_q;

`ifdef SYN_ERR_COUNT_EN
    logic [7:0] err_cw_cnt_q;

    // Saturating count of nonzero-syndrome codewords, dropped sets included.
    always_ff @(posedge CLK) begin
        if (RESET_GLOBAL)
            err_cw_cnt_q <= '0;
        else if (capture && !push_word.zero && (err_cw_cnt_q != 8'hFF))
            err_cw_cnt_q <= err_cw_cnt_q + 8'd1;
    end

    assign ERR_CW_CNT = err_cw_cnt_q;
`endif

endmodule

// File: tb/tb_syndrome_frame_ctrl.sv
// Self-checking bench for syndrome_frame_ctrl. Four behavioural syndrome
// cells driven by the DUT's CONTROL feed SYN_IN; a transaction-level model
// (direct power-sum syndromes plus a queue for the FIFO) is compared with
// the DUT every cycle, and directed tests pin literal expectations.
module tb_syndrome_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_GLOBAL;
    logic        IN_VALID;
    logic        IN_SOF;
    logic [3:0]  CONTROL;
    logic [15:0] SYN_IN;
    logic [15:0] SYN_OUT;
    logic        SYN_ZERO;
    logic        SYN_VALID;
    logic        SYN_READY;
    logic        FRAME_ERR;
    logic        OVERFLOW;
`ifdef SYN_ERR_COUNT_EN
    logic [7:0]  ERR_CW_CNT;
`endif

    logic [3:0]  sym;
    logic [3:0]  cw [15];

    int n_cmp  = 0;
    int n_fail = 0;
    int ferr_seen = 0;
    int ovf_seen  = 0;

    always #5 CLK = ~CLK;

    syndrome_frame_ctrl dut (
        .CLK          (CLK),
        .RESET_GLOBAL (RESET_GLOBAL),
        .IN_VALID     (IN_VALID),
        .IN_SOF       (IN_SOF),
        .CONTROL      (CONTROL),
        .SYN_IN       (SYN_IN),
        .SYN_OUT      (SYN_OUT),
        .SYN_ZERO     (SYN_ZERO),
        .SYN_VALID    (SYN_VALID),
        .SYN_READY    (SYN_READY),
        .FRAME_ERR    (FRAME_ERR),
        .OVERFLOW     (OVERFLOW)
`ifdef SYN_ERR_COUNT_EN
        ,
        .ERR_CW_CNT   (ERR_CW_CNT)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // GF(16) arithmetic, primitive polynomial x^4 + x + 1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) p = p ^ x;
            x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_pow(input int e);
        logic [3:0] r;
        r = 4'h1;
        for (int k = 0; k < (e % 15); k++) r = gf_mul(r, 4'h2);
        return r;
    endfunction

    // ---------------- syndrome cells (environment) ----------------
    logic [3:0] cell_reg [4];

    always_comb begin
        SYN_IN = '0;
        for (int i = 0; i < 4; i++)
            SYN_IN[4*i +: 4] = gf_mul(cell_reg[i] & CONTROL, gf_pow(i + 1)) ^ sym;
    end

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (RESET_GLOBAL)  cell_reg[i] <= 4'h0;
            else if (IN_VALID) cell_reg[i] <= SYN_IN[4*i +: 4];
        end
    end

    // ---------------- transaction-level model ----------------
    int          m_cnt  = 0;      // symbols received in current codeword, 0 = none
    logic        m_live = 1'b0;
    logic        m_ferr = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [7:0]  m_errcnt = 8'h0;
    logic [15:0] m_q [$];
    logic [3:0]  m_syms [15];

    // S_i = sum over j of r_j * alpha^(i*(14-j)), r_0 the first symbol.
    function automatic logic [15:0] ref_syndrome();
        logic [15:0] s;
        logic [3:0]  acc;
        s = '0;
        for (int i = 1; i <= 4; i++) begin
            acc = 4'h0;
            for (int j = 0; j < 15; j++)
                acc = acc ^ gf_mul(m_syms[j], gf_pow(i * (14 - j)));
            s[4*(i-1) +: 4] = acc;
        end
        return s;
    endfunction

    always @(posedge CLK) begin : model
        logic        cap;
        logic        pop;
        logic [15:0] cap_set;
        if (RESET_GLOBAL) begin
            m_cnt    = 0;
            m_q.delete();
            m_ferr   = 1'b0;
            m_ovf    = 1'b0;
            m_errcnt = 8'h0;
            m_live   = 1'b1;
        end else if (m_live) begin
            cap     = 1'b0;
            cap_set = '0;
            pop     = (m_q.size() != 0) && SYN_READY;
            m_ferr  = 1'b0;
            m_ovf   = 1'b0;
            if (IN_VALID) begin
                if (IN_SOF) begin
                    if (m_cnt != 0) m_ferr = 1'b1;
                    m_syms[0] = sym;
                    m_cnt = 1;
                end else if (m_cnt != 0) begin
                    m_syms[m_cnt] = sym;
                    m_cnt++;
                    if (m_cnt == 15) begin
                        cap     = 1'b1;
                        cap_set = ref_syndrome();
                        m_cnt   = 0;
                    end
                end
            end else if (m_cnt != 0) begin
                m_ferr = 1'b1;
                m_cnt  = 0;
            end
            if (pop) void'(m_q.pop_front());
            if (cap) begin
                if (cap_set != 16'h0 && m_errcnt != 8'hFF) m_errcnt++;
                if (m_q.size() < 2) m_q.push_back(cap_set);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_live) begin
            check("control", 16'(CONTROL),
                  ((m_cnt == 0) || (IN_VALID && IN_SOF)) ? 16'h0 : 16'hF);
            check("syn_valid", 16'(SYN_VALID), 16'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("syn_out", SYN_OUT, m_q[0]);
                check("syn_zero", 16'(SYN_ZERO), 16'(m_q[0] == 16'h0));
            end
            check("frame_err", 16'(FRAME_ERR), 16'(m_ferr));
            check("overflow", 16'(OVERFLOW), 16'(m_ovf));
`ifdef SYN_ERR_COUNT_EN
            check("err_cw_cnt", 16'(ERR_CW_CNT), 16'(m_errcnt));
`endif
            if (FRAME_ERR) ferr_seen++;
            if (OVERFLOW)  ovf_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic s, input logic [3:0] d);
        IN_VALID = v;
        IN_SOF   = s;
        sym      = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_syms(input int n);
        for (int j = 0; j < n; j++) begin
            IN_VALID = 1'b1;
            IN_SOF   = (j == 0);
            sym      = cw[j];
            #1;
            if (j == 0) check("ctrl_first_sym", 16'(CONTROL), 16'h0);
            if (j == 1) check("ctrl_second_sym", 16'(CONTROL), 16'hF);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_cw();
        drive_syms(15);
        IN_VALID = 1'b0;
        IN_SOF   = 1'b0;
        sym      = 4'h0;
    endtask

    task automatic fill_cw(input logic [3:0] base, input logic [3:0] last);
        for (int j = 0; j < 15; j++) cw[j] = base;
        cw[14] = last;
    endtask

    int f0, o0;

    initial begin
        RESET_GLOBAL = 1'b1;
        IN_VALID     = 1'b0;
        IN_SOF       = 1'b0;
        sym          = 4'h0;
        SYN_READY    = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_syn_valid", 16'(SYN_VALID), 16'h0);
        check("rst_syn_out",   SYN_OUT,        16'h0);
        check("rst_syn_zero",  16'(SYN_ZERO),  16'h0);
        check("rst_frame_err", 16'(FRAME_ERR), 16'h0);
        check("rst_overflow",  16'(OVERFLOW),  16'h0);
        check("rst_control",   16'(CONTROL),   16'h0);
        RESET_GLOBAL = 1'b0;
        drive(1'b0, 1'b0, 4'h0);

        // All-zero codeword.
        fill_cw(4'h0, 4'h0);
        send_cw();
        check("zero_cw_valid", 16'(SYN_VALID), 16'h1);
        check("zero_cw_out",   SYN_OUT,        16'h0000);
        check("zero_cw_flag",  16'(SYN_ZERO),  16'h1);

        // Single error in the last symbol, back-to-back with the previous.
        fill_cw(4'h0, 4'h5);
        send_cw();
        check("last_err_valid", 16'(SYN_VALID), 16'h1);
        check("last_err_out",   SYN_OUT,        16'h5555);
        check("last_err_flag",  16'(SYN_ZERO),  16'h0);
`ifdef SYN_ERR_COUNT_EN
        check("last_err_cnt", 16'(ERR_CW_CNT), 16'h1);
`endif

        // Single error value 1 in the first symbol: S_i = alpha^(14i).
        fill_cw(4'h0, 4'h0);
        cw[0] = 4'h1;
        send_cw();
        check("first_err_out", SYN_OUT, 16'hEFD9);

        // Gap after seven nonzero symbols, then a clean codeword.
        f0 = ferr_seen;
        fill_cw(4'h7, 4'h7);
        drive_syms(7);
        drive(1'b0, 1'b0, 4'h0);
        check("gap_frame_err", 16'(FRAME_ERR), 16'h1);
        check("gap_no_valid",  16'(SYN_VALID), 16'h0);
        fill_cw(4'h0, 4'h0);
        send_cw();
        check("after_gap_out",  SYN_OUT,       16'h0000);
        check("after_gap_flag", 16'(SYN_ZERO), 16'h1);
        check("gap_err_count",  16'(ferr_seen - f0), 16'h1);

        // Backpressure: three back-to-back codewords into a 2-deep FIFO.
        drive(1'b0, 1'b0, 4'h0);
        SYN_READY = 1'b0;
        o0 = ovf_seen;
        fill_cw(4'h0, 4'h1);
        send_cw();
        fill_cw(4'h0, 4'h2);
        send_cw();
        fill_cw(4'h0, 4'h3);
        send_cw();
        check("bp_overflow", 16'(OVERFLOW), 16'h1);
        check("bp_head_1",   SYN_OUT,       16'h1111);
        repeat (3) drive(1'b0, 1'b0, 4'h0);
        check("bp_stall_head",  SYN_OUT,        16'h1111);
        check("bp_stall_valid", 16'(SYN_VALID), 16'h1);
        SYN_READY = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_head_2", SYN_OUT, 16'h2222);
        @(posedge CLK);
        #1;
        check("bp_drained", 16'(SYN_VALID), 16'h0);
        check("bp_ovf_count", 16'(ovf_seen - o0), 16'h1);
`ifdef SYN_ERR_COUNT_EN
        check("bp_err_cnt", 16'(ERR_CW_CNT), 16'h5);
`endif

        // Restart: SOF reasserted when sym_cnt is 9.
        f0 = ferr_seen;
        fill_cw(4'h4, 4'h4);
        drive_syms(9);
        fill_cw(4'h0, 4'h9);
        send_cw();
        check("restart_out", SYN_OUT, 16'h9999);
        check("restart_ferr_count", 16'(ferr_seen - f0), 16'h1);

        // Reset mid-codeword with a set pending in the FIFO.
        drive(1'b0, 1'b0, 4'h0);
        SYN_READY = 1'b0;
        fill_cw(4'h0, 4'hA);
        send_cw();
        fill_cw(4'h3, 4'h3);
        drive_syms(5);
        RESET_GLOBAL = 1'b1;
        drive(1'b0, 1'b0, 4'h0);
        check("mid_rst_valid",   16'(SYN_VALID), 16'h0);
        check("mid_rst_control", 16'(CONTROL),   16'h0);
        RESET_GLOBAL = 1'b0;
        SYN_READY    = 1'b1;
        fill_cw(4'h0, 4'h6);
        send_cw();
        check("post_rst_out", SYN_OUT, 16'h6666);
`ifdef SYN_ERR_COUNT_EN
        check("post_rst_err_cnt", 16'(ERR_CW_CNT), 16'h1);
`endif

        repeat (4) drive(1'b0, 1'b0, 4'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/syndrome_frame_ctrl.md
Name: syndrome_frame_ctrl

Overview:
Framing and capture stage wrapped around the four syndrome cells of the RS(15,11) decoder over GF(16).
- Counts incoming symbols and drives the shared CONTROL mask. CONTROL clears cell feedback on the first symbol of each codeword.
- Captures the four combinational cell outputs (OUT_SERIAL) on the 15th symbol.
- Buffers syndrome sets in a small FIFO and hands them to the key-equation stage with a valid/ready handshake.

Parameters:
N_SYM, 15, symbols per codeword.
SYM_W, 4, symbol width (GF(16)).
N_SYN, 4, syndromes per codeword (2t).
FIFO_DEPTH, 2, syndrome-set buffer entries (power of two).

Ports:
CLK  in  1  system clock; all logic on rising edge.
RESET_GLOBAL  in  1  synchronous, active-high reset.
IN_VALID  in  1  symbol on bus this cycle; must stay high for 15 consecutive cycles per codeword.
IN_SOF  in  1  qualifies the first symbol of a codeword; meaningful only with IN_VALID.
CONTROL  out  SYM_W  feedback mask to all syndrome cells: 4'h0 on first symbol or idle, 4'hF otherwise.
SYN_IN  in  N_SYN*SYM_W  cell OUT_SERIAL lanes, {S4,S3,S2,S1}, S1 in bits [3:0].
SYN_OUT  out  N_SYN*SYM_W  FIFO head syndrome set.
SYN_ZERO  out  1  head set is all-zero (codeword clean).
SYN_VALID  out  1  head entry valid.
SYN_READY  in  1  downstream accepts head.
FRAME_ERR  out  1  one-cycle pulse: codeword aborted.
OVERFLOW  out  1  one-cycle pulse: completed set dropped, FIFO full.

Behaviour:
- Reset (synchronous, RESET_GLOBAL=1 at the edge):
  - sym_cnt=0, FIFO empty.
  - SYN_VALID=0, SYN_OUT=0, SYN_ZERO=0, FRAME_ERR=0, OVERFLOW=0.
  - Reset mid-codeword discards the partial codeword.
- States: IDLE, ACCUM.
- CONTROL is combinational from state:
  - 4'h0 in IDLE, or in ACCUM when IN_SOF is restarting.
  - 4'hF in ACCUM otherwise.
- IDLE:
  - IN_VALID&IN_SOF → ACCUM, sym_cnt=1.
  - IN_VALID without IN_SOF is ignored; no error.
- ACCUM:
  - Each IN_VALID cycle increments sym_cnt.
  - Capture: the cycle with IN_VALID and sym_cnt==N_SYM-1 is the 15th symbol. SYN_IN that cycle is the final syndrome set (the cell output is combinational, so it is read before the cell register updates).
  - The set is written to the FIFO at that edge; sym_cnt→0; state→IDLE.
  - Back-to-back codewords: if IN_SOF arrives in the cycle immediately after capture, IDLE accepts it. No bubble is required.
- Abort:
  - IN_VALID=0 in ACCUM → FRAME_ERR pulse next cycle, →IDLE, sym_cnt=0.
  - IN_VALID&IN_SOF with sym_cnt≠0 → FRAME_ERR pulse. This symbol restarts a new codeword (CONTROL=0, sym_cnt=1).
- FIFO:
  - Registered outputs; SYN_VALID asserts the cycle after capture.
  - Latency: 15th symbol edge → SYN_VALID=1 one cycle later.
  - Pop on SYN_VALID&SYN_READY.
  - Capture into a full FIFO: set dropped, OVERFLOW pulse, contents unchanged.
  - Simultaneous capture and pop when full: pop first, write succeeds, no OVERFLOW.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.
- SYN_ZERO = (head set == 0), registered alongside SYN_OUT.
- SYN_OUT and SYN_ZERO hold stable while SYN_VALID&!SYN_READY.

Optional Feature:
SYN_ERR_COUNT_EN
- Defined:
  - Extra output ERR_CW_CNT, 8 bits.
  - Saturating count of captured codewords with a nonzero syndrome set, counted at capture, including dropped ones.
  - Cleared by RESET_GLOBAL; holds at 8'hFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
Shared package rs15_pkg:
- constants N_SYM=15, SYM_W=4, N_SYN=4, CW_CNT_W=4;
- syndrome-set type (N_SYN×SYM_W packed);
- state encoding for IDLE/ACCUM.

One sub-module: syn_fifo.
- Depth-parameterised synchronous FIFO carrying {zero_flag, set}.
- Exposes full/empty.

Framing FSM and CONTROL generation stay in the top module.

Test Plan:
- All-zero codeword: IN_SOF at cycle 0, 15 symbols 4'h0, SYN_IN driven by real cells, SYN_READY=1. Expect CONTROL=0 at cycle 0 and F at cycles 1–14; SYN_VALID at cycle 15, SYN_OUT=16'h0000, SYN_ZERO=1.
- Single error at last symbol: symbols 0 except the 15th = 4'h5. Expect SYN_OUT=16'h5555, SYN_ZERO=0; with SYN_ERR_COUNT_EN, ERR_CW_CNT=1.
- Gap at symbol 7: IN_VALID low one cycle. Expect FRAME_ERR pulse, no SYN_VALID. Next SOF codeword of zeros yields SYN_OUT=0, proving feedback was cleared.
- Backpressure: SYN_READY=0, three back-to-back codewords. First two are buffered; third gives an OVERFLOW pulse. Raise SYN_READY: sets 1 and 2 pop in order, SYN_OUT stable while stalled.
- Restart: IN_SOF reasserted at sym_cnt=9. Expect FRAME_ERR, CONTROL=0 that cycle, and capture 15 symbols later.
- Reset mid-codeword at sym_cnt=5. Expect SYN_VALID=0 and CONTROL=0 the next cycle, FIFO empty; the following codeword is captured correctly.
